// File: rtl/mmap_lsu_if.sv
// Memory-mapped region bus: the CPU side issues single-cycle accesses and the
// region answers combinationally in the same cycle.
interface mmap_region #(
    parameter int ADDR_W = 24
);
    logic              rw_request;
    logic              is_write;
    logic              request_exec;
    logic [ADDR_W-1:2] addr;
    logic [31:0]       write_word;
    logic [3:0]        byte_en;
    logic [31:0]       read_word;
    logic              word_level_io;
    logic              fault_read;
    logic              fault_write;
    logic              fault_einval;

    modport CPU (
        output rw_request, is_write, request_exec, addr, write_word, byte_en,
        input  read_word, word_level_io, fault_read, fault_write, fault_einval
    );

    modport MEM (
        input  rw_request, is_write, request_exec, addr, write_word, byte_en,
        output read_word, word_level_io, fault_read, fault_write, fault_einval
    );
endinterface

// File: rtl/mmap_lsu.sv
// Data-side load/store unit: one access at a time, read-modify-write emulation of
// sub-word stores on word-only regions, fault cause mapping and sticky fault address.
module mmap_lsu #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_cause,
    output logic              fault_pending,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clear,
    mmap_region.CPU           bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merged_q, merged_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        resp_cause_q, resp_cause_d;
    logic              fault_pending_q, fault_pending_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    logic [3:0]        lane_be;
    logic [31:0]       lane_data;
    logic              rmw_read;
    logic              cyc_write;
    logic [1:0]        cyc_cause;
    logic              fault_evt;
    logic [ADDR_W-1:0] fault_evt_addr;
    logic              misaligned;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] a, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*a +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    return sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'd1:    return sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                               input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return m;
    endfunction

    always_comb begin
        case (size_q)
            2'd0:    lane_be = 4'b0001 << addr_q[1:0];
            2'd1:    lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
        case (size_q)
            2'd0:    lane_data = {4{wdata_q[7:0]}};
            2'd1:    lane_data = {2{wdata_q[15:0]}};
            default: lane_data = wdata_q;
        endcase
    end

    // The read phase of an RMW store is only known once the region answers.
    assign rmw_read = (state_q == ACCESS) && write_q && (size_q != 2'd2) && bus.word_level_io;

    always_comb begin
        bus.rw_request   = 1'b0;
        bus.is_write     = 1'b0;
        bus.request_exec = 1'b0;
        bus.addr         = '0;
        bus.write_word   = 32'd0;
        bus.byte_en      = 4'd0;
        cyc_write        = 1'b0;
        case (state_q)
            ACCESS: begin
                cyc_write        = write_q && !rmw_read;
                bus.rw_request   = 1'b1;
                bus.is_write     = cyc_write;
                bus.addr         = addr_q[ADDR_W-1:2];
                bus.write_word   = lane_data;
                bus.byte_en      = lane_be;
            end
            RMW_WR: begin
                cyc_write        = 1'b1;
                bus.rw_request   = 1'b1;
                bus.is_write     = 1'b1;
                bus.addr         = addr_q[ADDR_W-1:2];
                bus.write_word   = merged_q;
                bus.byte_en      = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        cyc_cause = 2'd0;
        if (bus.fault_einval) begin
            cyc_cause = 2'd3;
        end else if (cyc_write ? bus.fault_write : bus.fault_read) begin
            cyc_cause = write_q ? 2'd2 : 2'd1;
        end
    end

    assign misaligned = (req_size == 2'd3) ||
                        (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'd0);

    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        size_d          = size_q;
        signed_d        = signed_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        merged_d        = merged_q;
        resp_rdata_d    = resp_rdata_q;
        resp_cause_d    = resp_cause_q;
        fault_pending_d = fault_pending_q;
        fault_addr_d    = fault_addr_q;
        fault_evt       = 1'b0;
        fault_evt_addr  = addr_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d        = req_write;
                    size_d         = req_size;
                    signed_d       = req_signed;
                    addr_d         = req_addr;
                    wdata_d        = req_wdata;
                    fault_evt_addr = req_addr;
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_rdata_d = 32'd0;
                        resp_cause_d = 2'd3;
                        fault_evt    = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cyc_cause != 2'd0) begin
                    state_d      = RESP;
                    resp_rdata_d = 32'd0;
                    resp_cause_d = cyc_cause;
                    fault_evt    = 1'b1;
                end else if (rmw_read) begin
                    merged_d = lane_merge(bus.read_word, lane_data, lane_be);
                    state_d  = RMW_WR;
                end else begin
                    state_d      = RESP;
                    resp_rdata_d = write_q ? 32'd0
                                           : load_extract(bus.read_word, size_q, addr_q[1:0], signed_q);
                    resp_cause_d = 2'd0;
                end
            end
            RMW_WR: begin
                state_d      = RESP;
                resp_rdata_d = 32'd0;
                resp_cause_d = cyc_cause;
                fault_evt    = (cyc_cause != 2'd0);
            end
            default: state_d = IDLE;
        endcase

        // A fault arriving with a clear still wins, so it is never lost.
        if (fault_evt && (!fault_pending_q || fault_clear)) begin
            fault_pending_d = 1'b1;
            fault_addr_d    = fault_evt_addr;
        end else if (fault_clear) begin
            fault_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            write_q         <= 1'b0;
            size_q          <= 2'd0;
            signed_q        <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= 32'd0;
            merged_q        <= 32'd0;
            resp_rdata_q    <= 32'd0;
            resp_cause_q    <= 2'd0;
            fault_pending_q <= 1'b0;
            fault_addr_q    <= '0;
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            merged_q        <= merged_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_cause_q    <= resp_cause_d;
            fault_pending_q <= fault_pending_d;
            fault_addr_q    <= fault_addr_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = resp_rdata_q;
    assign resp_cause    = resp_cause_q;
    assign fault_pending = fault_pending_q;
    assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_mmap_lsu.sv
// Directed bench for mmap_lsu: the bench plays the region by driving the bus
// response signals and logs every bus cycle the unit issues.
module tb_mmap_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [23:0] req_addr = 24'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic        fault_pending;
    logic [23:0] fault_addr;
    logic        fault_clear = 1'b0;

    mmap_region #(.ADDR_W(24)) bus_if ();

    mmap_lsu #(.ADDR_W(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_cause(resp_cause), .fault_pending(fault_pending), .fault_addr(fault_addr),
        .fault_clear(fault_clear), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int          nlog;
    logic        log_wr[4];
    logic [31:0] log_ww[4];
    logic [3:0]  log_be[4];
    logic [21:0] log_addr[4];

    int          lat;
    logic [31:0] r_rdata;
    logic [1:0]  r_cause;

    always @(negedge clk) begin
        if (bus_if.rw_request && nlog < 4) begin
            log_wr[nlog]   = bus_if.is_write;
            log_ww[nlog]   = bus_if.write_word;
            log_be[nlog]   = bus_if.byte_en;
            log_addr[nlog] = bus_if.addr;
            nlog = nlog + 1;
        end
    end

    task automatic region(input logic [31:0] rw, input logic wl, input logic fr,
                          input logic fw, input logic fe);
        bus_if.read_word     = rw;
        bus_if.word_level_io = wl;
        bus_if.fault_read    = fr;
        bus_if.fault_write   = fw;
        bus_if.fault_einval  = fe;
    endtask

    task automatic do_req(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [23:0] a, input logic [31:0] wd, input logic clr);
        logic got;
        nlog = 0;
        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        fault_clear = clr;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; lat = i; r_rdata = resp_rdata; r_cause = resp_cause;
            end else begin
                @(posedge clk);
                #1 fault_clear = 1'b0;
            end
        end
        fault_clear = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL %s_timeout resp_valid not seen within 10 cycles", name);
            r_rdata = 32'hx; r_cause = 2'bx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'd0 || resp_cause !== 2'd0) begin n_fail++; $display("FAIL rst_resp got %h/%0d exp 0/0", resp_rdata, resp_cause); end
        n_checks++; if (fault_pending !== 1'b0 || fault_addr !== 24'd0) begin n_fail++; $display("FAIL rst_fault got %b/%h exp 0/0", fault_pending, fault_addr); end
        n_checks++; if ({bus_if.rw_request, bus_if.is_write, bus_if.request_exec, bus_if.byte_en, bus_if.write_word, bus_if.addr} !== '0) begin n_fail++; $display("FAIL rst_bus outputs not zero rw=%b be=%b", bus_if.rw_request, bus_if.byte_en); end
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_word_load();
        region(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req("word_load", 1'b0, 2'd2, 1'b0, 24'h000100, 32'd0, 1'b0);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL word_load_lat got %0d exp 2", lat); end
        n_checks++; if (r_rdata !== 32'hDEADBEEF || r_cause !== 2'd0) begin n_fail++; $display("FAIL word_load_resp got %h/%0d exp deadbeef/0", r_rdata, r_cause); end
        n_checks++; if (nlog !== 1 || log_addr[0] !== 22'h40 || log_wr[0] !== 1'b0) begin n_fail++; $display("FAIL word_load_bus got n=%0d addr=%h wr=%b exp 1/40/0", nlog, log_addr[0], log_wr[0]); end
    endtask

    task automatic test_subword_load();
        region(32'h80123456, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req("sbyte", 1'b0, 2'd0, 1'b1, 24'h000103, 32'd0, 1'b0);
        n_checks++; if (r_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL sbyte_rdata got %h exp ffffff80", r_rdata); end
        do_req("ubyte", 1'b0, 2'd0, 1'b0, 24'h000103, 32'd0, 1'b0);
        n_checks++; if (r_rdata !== 32'h00000080) begin n_fail++; $display("FAIL ubyte_rdata got %h exp 00000080", r_rdata); end
        do_req("shalf_hi", 1'b0, 2'd1, 1'b1, 24'h000102, 32'd0, 1'b0);
        n_checks++; if (r_rdata !== 32'hFFFF8012) begin n_fail++; $display("FAIL shalf_hi_rdata got %h exp ffff8012", r_rdata); end
        do_req("shalf_lo", 1'b0, 2'd1, 1'b1, 24'h000100, 32'd0, 1'b0);
        n_checks++; if (r_rdata !== 32'h00003456) begin n_fail++; $display("FAIL shalf_lo_rdata got %h exp 00003456", r_rdata); end
    endtask

    task automatic test_stores();
        region(32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0);
        do_req("rmw", 1'b1, 2'd0, 1'b0, 24'h000102, 32'h000000AB, 1'b0);
        n_checks++; if (lat !== 3 || r_cause !== 2'd0 || r_rdata !== 32'd0) begin n_fail++; $display("FAIL rmw_resp got lat=%0d cause=%0d rdata=%h exp 3/0/0", lat, r_cause, r_rdata); end
        n_checks++; if (nlog !== 2 || log_wr[0] !== 1'b0 || log_wr[1] !== 1'b1) begin n_fail++; $display("FAIL rmw_phases got n=%0d wr0=%b wr1=%b exp 2/0/1", nlog, log_wr[0], log_wr[1]); end
        n_checks++; if (log_ww[1] !== 32'h11AB3344 || log_be[1] !== 4'b1111 || log_addr[1] !== 22'h40) begin n_fail++; $display("FAIL rmw_write got ww=%h be=%b addr=%h exp 11ab3344/1111/40", log_ww[1], log_be[1], log_addr[1]); end
        region(32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req("dbyte", 1'b1, 2'd0, 1'b0, 24'h000102, 32'h000000AB, 1'b0);
        n_checks++; if (lat !== 2 || nlog !== 1 || log_wr[0] !== 1'b1) begin n_fail++; $display("FAIL dbyte_cycle got lat=%0d n=%0d wr=%b exp 2/1/1", lat, nlog, log_wr[0]); end
        n_checks++; if (log_ww[0] !== 32'hABABABAB || log_be[0] !== 4'b0100) begin n_fail++; $display("FAIL dbyte_lanes got ww=%h be=%b exp abababab/0100", log_ww[0], log_be[0]); end
        do_req("dhalf", 1'b1, 2'd1, 1'b0, 24'h000102, 32'h0000BEEF, 1'b0);
        n_checks++; if (log_ww[0] !== 32'hBEEFBEEF || log_be[0] !== 4'b1100) begin n_fail++; $display("FAIL dhalf_lanes got ww=%h be=%b exp beefbeef/1100", log_ww[0], log_be[0]); end
        region(32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0);
        do_req("wword", 1'b1, 2'd2, 1'b0, 24'h000104, 32'hCAFEF00D, 1'b0);
        n_checks++; if (lat !== 2 || nlog !== 1 || log_ww[0] !== 32'hCAFEF00D || log_be[0] !== 4'b1111 || log_wr[0] !== 1'b1) begin n_fail++; $display("FAIL wword_direct got lat=%0d n=%0d ww=%h be=%b exp 2/1/cafef00d/1111", lat, nlog, log_ww[0], log_be[0]); end
    endtask

    task automatic test_faults();
        region(32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_req("f1", 1'b0, 2'd2, 1'b0, 24'h000200, 32'd0, 1'b0);
        n_checks++; if (r_cause !== 2'd1 || r_rdata !== 32'd0) begin n_fail++; $display("FAIL f1_resp got %0d/%h exp 1/0", r_cause, r_rdata); end
        n_checks++; if (fault_pending !== 1'b1 || fault_addr !== 24'h000200) begin n_fail++; $display("FAIL f1_reg got %b/%h exp 1/000200", fault_pending, fault_addr); end
        do_req("f2", 1'b0, 2'd2, 1'b0, 24'h000300, 32'd0, 1'b0);
        n_checks++; if (fault_addr !== 24'h000200) begin n_fail++; $display("FAIL f2_sticky got %h exp 000200", fault_addr); end
        do_req("f3", 1'b0, 2'd2, 1'b0, 24'h000400, 32'd0, 1'b1);
        n_checks++; if (fault_pending !== 1'b1 || fault_addr !== 24'h000400) begin n_fail++; $display("FAIL f3_clear_and_fault got %b/%h exp 1/000400", fault_pending, fault_addr); end
        fault_clear = 1'b1;
        @(posedge clk); #1 fault_clear = 1'b0;
        n_checks++; if (fault_pending !== 1'b0) begin n_fail++; $display("FAIL clear got %b exp 0", fault_pending); end
        region(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_req("wfault", 1'b1, 2'd2, 1'b0, 24'h000500, 32'h12345678, 1'b0);
        n_checks++; if (r_cause !== 2'd2 || fault_addr !== 24'h000500) begin n_fail++; $display("FAIL wfault got %0d/%h exp 2/000500", r_cause, fault_addr); end
        region(32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_req("rmwfault", 1'b1, 2'd0, 1'b0, 24'h000501, 32'h000000AB, 1'b0);
        n_checks++; if (r_cause !== 2'd2 || lat !== 2 || nlog !== 1) begin n_fail++; $display("FAIL rmwfault got cause=%0d lat=%0d n=%0d exp 2/2/1", r_cause, lat, nlog); end
        region(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_req("einval", 1'b0, 2'd2, 1'b0, 24'h000600, 32'd0, 1'b0);
        n_checks++; if (r_cause !== 2'd3 || fault_addr !== 24'h000500) begin n_fail++; $display("FAIL einval got %0d/%h exp 3/000500", r_cause, fault_addr); end
        region(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_misaligned();
        do_req("mis_word", 1'b0, 2'd2, 1'b0, 24'h000002, 32'd0, 1'b0);
        n_checks++; if (lat !== 1 || nlog !== 0 || r_cause !== 2'd3) begin n_fail++; $display("FAIL mis_word got lat=%0d n=%0d cause=%0d exp 1/0/3", lat, nlog, r_cause); end
        do_req("mis_half", 1'b1, 2'd1, 1'b0, 24'h000101, 32'd0, 1'b0);
        n_checks++; if (lat !== 1 || nlog !== 0 || r_cause !== 2'd3) begin n_fail++; $display("FAIL mis_half got lat=%0d n=%0d cause=%0d exp 1/0/3", lat, nlog, r_cause); end
        do_req("size3", 1'b0, 2'd3, 1'b0, 24'h000100, 32'd0, 1'b0);
        n_checks++; if (lat !== 1 || nlog !== 0 || r_cause !== 2'd3) begin n_fail++; $display("FAIL size3 got lat=%0d n=%0d cause=%0d exp 1/0/3", lat, nlog, r_cause); end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        first = 0; second = 0;
        region(32'h01020304, 1'b0, 1'b0, 1'b0, 1'b0);
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 24'h000100;
        req_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 12 && second == 0; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (first == 0) first = i;
                else second = i;
            end
        end
        req_valid = 1'b0;
        n_checks++; if (first !== 2 || second !== 5) begin n_fail++; $display("FAIL b2b_timing got resp at %0d,%0d exp 2,5", first, second); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic seen;
        region(32'h01020304, 1'b0, 1'b0, 1'b0, 1'b0);
        req_write = 1'b0; req_size = 2'd2; req_addr = 24'h000100; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_if.rw_request !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_access got rw=%b ready=%b exp 1/0", bus_if.rw_request, req_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus_if.rw_request, bus_if.is_write, bus_if.byte_en, bus_if.write_word, bus_if.addr} !== '0) begin n_fail++; $display("FAIL mid_bus_drop got rw=%b be=%b addr=%h exp zeros", bus_if.rw_request, bus_if.byte_en, bus_if.addr); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || fault_pending !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp got resp=%b pending=%b exp 0/0", seen, fault_pending); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release got ready=%b resp=%b exp 1/0", req_ready, resp_valid); end
    endtask

    initial begin
        nlog = 0;
        region(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_word_load();
        test_subword_load();
        test_stores();
        test_faults();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmap_lsu.md
# mmap_lsu

Data-side load/store unit between the CPU core and the memory-mapped region bus; it is the stage directly upstream of every `mmap_region.MEM` region (zero region, RAM, I/O). It accepts one load/store at a time over a valid/ready handshake and performs the bus access. It emulates sub-word stores with read-modify-write when the region reports `word_level_io`, maps region fault flags to a cause code, and keeps a sticky fault-address register.

## Interface
- `ADDR_W`, default 24: byte-address width; the bus carries word address `[ADDR_W-1:2]`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit idle; the request is accepted when `req_valid && req_ready`.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word; 3 is invalid.
- `req_signed`  in  1: sign-extend sub-word loads.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: one-cycle response pulse.
- `resp_rdata`  out  32: load data, extended; 0 for stores and faults.
- `resp_cause`  out  2: 0 = ok, 1 = read fault, 2 = write fault, 3 = einval.
- `fault_pending`  out  1: sticky fault flag.
- `fault_addr`  out  ADDR_W: byte address of the first unacknowledged fault.
- `fault_clear`  in  1: clears `fault_pending`.
- `bus`  modport `mmap_region.CPU`: drives `rw_request`, `is_write`, `addr`, `write_word`, `byte_en[3:0]`; `request_exec` is tied to 0. Samples `read_word`, `word_level_io`, `fault_read`, `fault_write`, `fault_einval`.

## Operation
- FSM states: IDLE, ACCESS, RMW_WR, RESP. `req_ready` = (state == IDLE).
- IDLE, on accept: latch the request.
  - Misaligned (half with `addr[0]`, word with `addr[1:0]` ≠ 0) or `req_size` = 3: go to RESP with cause 3. No bus cycle.
  - Otherwise go to ACCESS.
- ACCESS: `rw_request` = 1 for exactly this cycle. Regions are combinational, so responses are sampled in the same cycle.
  - Load: `is_write` = 0.
  - Word store, or sub-word store with `word_level_io` = 0: `is_write` = 1. The data is replicated to the byte lanes. `byte_en` = 0001<<a for bytes, 0011<<(2·a[1]) for halves.
  - Sub-word store with `word_level_io` = 1: this cycle is a read (`is_write` = 0). Capture `read_word`, merge the store lanes, go to RMW_WR.
- RMW_WR: `rw_request` = 1, `is_write` = 1, `byte_en` = 1111, merged word; then go to RESP.
- Fault mapping: `fault_einval` gives cause 3. Otherwise `fault_write` on a store cycle or `fault_read` on a load cycle gives cause 1 for loads and 2 for stores.
  - A fault in the RMW read phase reports cause 2 and skips RMW_WR.
- Load data: select the lane by `addr[1:0]` (byte) or `addr[1]` (half); zero-extend, or sign-extend when `req_signed` = 1.
- RESP: `resp_valid` = 1 and the outputs are held from registers; then go to IDLE.
- Fault register: on any nonzero cause with `fault_pending` = 0, set `fault_pending` and load `fault_addr` with the request byte address.
  - Later faults do not overwrite it while pending.
  - `fault_clear` clears the flag. If clear and a new fault occur in the same cycle, the new fault is latched.
- Bus outputs are 0 in IDLE and RESP.

## Timing
- Reset (async assert): state IDLE. `resp_valid`, `resp_rdata`, `resp_cause`, `fault_pending`, `fault_addr` and all bus outputs are 0. `req_ready` = 1 after release.
- Reset mid-operation drops `rw_request` immediately and produces no response.
- Latency from accept edge to `resp_valid` cycle:
  - Misaligned: 1 cycle.
  - Load or direct store: 2 cycles.
  - RMW store: 3 cycles.
- Next accept is possible the cycle after RESP. Throughput is 1 access per 3 cycles (direct).
- `req_*` inputs are ignored while `req_ready` = 0.

## Test plan
- Word load at 0x000100, region returns 0xDEADBEEF, no fault -> ACCESS one cycle later with `addr` = 0x40, `is_write` = 0; `resp_valid` 2 cycles after accept with rdata 0xDEADBEEF, cause 0.
- Signed byte load at 0x000103 with `read_word` 0x80123456 -> rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Byte store 0xAB at 0x000102 to a `word_level_io` = 1 region holding 0x11223344 -> read cycle, then write cycle with 0x11AB3344 and `byte_en` 1111; resp at +3.
- Same store with `word_level_io` = 0 -> single write, `byte_en` 0100, `write_word` 0xABABABAB.
- Word load from the zero region (`fault_read` = 1) -> cause 1, `fault_pending` = 1, `fault_addr` = the request address. A second fault leaves `fault_addr` unchanged. `fault_clear` in the same cycle as a third fault latches the third address.
- Word load at 0x000002 -> no `rw_request`, cause 3 one cycle after accept. Then assert `rst_n` = 0 during an ACCESS cycle -> bus outputs 0 asynchronously and no `resp_valid`.
